// File: rtl/jk_ff_rr_arbiter.sv
// Round-robin sequencer sharing one JK-behaviour bit between NUM_REQ requesters.
// Optional statistics counters (toggle_cnt, cmd_cnt) are enabled by defining JK_ARB_STATS_EN.
module jk_ff_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] cmd_j,
   input  logic [NUM_REQ-1:0] cmd_k,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     gnt_id,
   output logic               busy,
   output logic               q
`ifdef JK_ARB_STATS_EN
   ,
   output logic [15:0]        toggle_cnt,
   output logic [15:0]        cmd_cnt
`endif
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]     gnt_id_q, gnt_id_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic               cmd_j_q, cmd_j_d;
   logic               cmd_k_q, cmd_k_d;
   logic               q_q, q_d;

   logic [NUM_REQ-1:0]   elig;
   logic [2*NUM_REQ-1:0] elig_dbl, j_dbl, k_dbl;
   logic [NUM_REQ-1:0]   elig_rot, j_rot, k_rot;

   function automatic logic jk_next(input logic j, input logic k, input logic cur);
      return (j & ~cur) | (~k & cur);
   endfunction

   // Rotate so that bit 0 corresponds to the pointer; the search then runs from bit 0 up.
   always_comb begin
      elig     = req & ~gnt_q;
      elig_dbl = {elig, elig} >> ptr_q;
      j_dbl    = {cmd_j, cmd_j} >> ptr_q;
      k_dbl    = {cmd_k, cmd_k} >> ptr_q;
      elig_rot = elig_dbl[NUM_REQ-1:0];
      j_rot    = j_dbl[NUM_REQ-1:0];
      k_rot    = k_dbl[NUM_REQ-1:0];
   end

   always_comb begin : arb
      logic found;
      int   win;
      found    = 1'b0;
      win      = 0;
      state_d  = IDLE;
      gnt_d    = '0;
      gnt_id_d = gnt_id_q;
      ptr_d    = ptr_q;
      cmd_j_d  = cmd_j_q;
      cmd_k_d  = cmd_k_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && elig_rot[k]) begin
            found   = 1'b1;
            win     = int'(ptr_q) + k;
            if (win >= NUM_REQ) win = win - NUM_REQ;
            state_d  = GRANT;
            gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            gnt_id_d = IDW'(win);
            ptr_d    = (win + 1 >= NUM_REQ) ? '0 : IDW'(win + 1);
            cmd_j_d  = j_rot[k];
            cmd_k_d  = k_rot[k];
         end
      end
   end

   // The command latched in the previous edge is applied at the edge ending its GRANT cycle.
   always_comb begin
      q_d = q_q;
      if (state_q == GRANT) q_d = jk_next(cmd_j_q, cmd_k_q, q_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         ptr_q    <= '0;
         q_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         ptr_q    <= ptr_d;
         q_q      <= q_d;
      end
   end

   always_ff @(posedge clk) begin
      cmd_j_q <= cmd_j_d;
      cmd_k_q <= cmd_k_d;
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = (state_q == GRANT);
   assign q      = q_q;

`ifdef JK_ARB_STATS_EN
   logic [15:0] cmd_cnt_q, cmd_cnt_d;
   logic [15:0] toggle_cnt_q, toggle_cnt_d;

   always_comb begin
      cmd_cnt_d    = cmd_cnt_q;
      toggle_cnt_d = toggle_cnt_q;
      if (state_q == GRANT) begin
         cmd_cnt_d = cmd_cnt_q + 16'd1;
         if (cmd_j_q && cmd_k_q) toggle_cnt_d = toggle_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_cnt_q    <= '0;
         toggle_cnt_q <= '0;
      end else begin
         cmd_cnt_q    <= cmd_cnt_d;
         toggle_cnt_q <= toggle_cnt_d;
      end
   end

   assign cmd_cnt    = cmd_cnt_q;
   assign toggle_cnt = toggle_cnt_q;
`endif

endmodule

// File: doc/jk_ff_rr_arbiter.md
Name: jk_ff_rr_arbiter

Overview:
- Shares one JK-behaviour storage bit (JK implemented on a D register, D = J&~Q | ~K&Q) between NUM_REQ requesters.
- Each requester posts a 2-bit JK command (hold/reset/set/toggle) with a req/gnt handshake.
- A round-robin scheduler grants one requester per cycle, latches its command and applies it to the shared bit.
- Sits between control agents and the JK flop datapath as its sole sequencer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDW, 2, width of gnt_id; must satisfy 2**IDW >= NUM_REQ

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  NUM_REQ  per-requester command request
cmd_j  input  NUM_REQ  per-requester J bit, valid while req high
cmd_k  input  NUM_REQ  per-requester K bit, valid while req high
gnt  output  NUM_REQ  one-hot grant, registered
gnt_id  output  IDW  index of granted requester, valid when busy=1
busy  output  1  high in the cycle a command is being applied
q  output  1  shared JK state bit

Behaviour:
- Reset: at a rising edge with rst=1: q=0, gnt=0, gnt_id=0, busy=0, state=IDLE, rr pointer=0. Reset overrides any pending or in-flight command; the latched command is discarded and q stays 0.
- States:
  - IDLE: no grant outstanding.
  - GRANT: one grant outstanding; gnt, busy and gnt_id are driven from state.
- Arbitration at each rising edge, rst=0:
  - eligible = req masked by the currently asserted gnt (the granted requester's req is ignored at that edge).
  - Search eligible from pointer upward, wrapping modulo NUM_REQ; the first hit wins.
- Winner i:
  - next state=GRANT, gnt=one-hot(i), gnt_id=i, busy=1.
  - Latch cmd_j[i] and cmd_k[i] into the command register.
  - pointer = (i+1) mod NUM_REQ.
- No winner: next state=IDLE, gnt=0, busy=0, pointer unchanged.
- Apply: at the edge ending a GRANT cycle, q updates from the latched command:
  - 00 hold
  - 01 q=0
  - 10 q=1
  - 11 q=~q
- Latency: req high at edge N gives gnt high in cycle N..N+1, and q is updated at edge N+1. Back-to-back grants to different requesters are allowed: throughput 1 command/cycle.
- Handshake:
  - Requester holds req, cmd_j and cmd_k stable until it observes gnt, then deasserts req in the gnt cycle.
  - If req is still high at the next edge while the requester is not granted, it is a new request.
  - The same requester cannot win two consecutive edges, because of the mask.
- Simultaneous events:
  - Apply of the old command and grant of a new one occur at the same edge.
  - The new command affects q one edge later.
- Single requester: served at most every other cycle. Alternating grants reach the same toggle result as sequential issue.
- cmd bits of non-requesting lanes are don't-care.

Optional Feature:
- Macro JK_ARB_STATS_EN.
- When defined, adds output ports toggle_cnt[15:0] and cmd_cnt[15:0]:
  - cmd_cnt increments at every apply edge.
  - toggle_cnt increments at every apply edge with latched command 11.
  - Both wrap from 16'hFFFF to 0, and both reset to 0 on rst.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset with req=4'b1111 held, cmds 10 -> during rst: q=0, gnt=0, busy=0. After release, first gnt=4'b0001 and gnt_id=0.
- req[2]=1 with jk=10, single cycle -> next cycle gnt=4'b0100, busy=1; q=1 after the following edge. Repeat with jk=01 -> q=0.
- All four requesters held high with jk=11 each, each dropping req upon its gnt -> grant order 0,1,2,3 on consecutive cycles; q toggles 4 times, ending equal to its initial value 0.
- Fairness wrap: pointer at 3, req=4'b1001 -> gnt 3 then 0. Next round with req=4'b1001 again -> grant 3 again only after 0.
- rst asserted in a GRANT cycle carrying jk=10 -> q stays 0, gnt=0 next cycle, pointer=0.
- With JK_ARB_STATS_EN defined: commands 11,11,10,00 applied -> cmd_cnt=4, toggle_cnt=2. Preload by 65535 toggles -> one more toggle wraps toggle_cnt to 0.
